// File: rtl/fetch_pkg.sv
// fetch_pkg: shared sizing constants and the fetch bundle type for the fetch
// bundle queue and its storage array.
//   FETCH_WIDTH       instruction slots per bundle
//   DEPTH             bundle entries (power of two)
//   SIZE_PC           PC width
//   SIZE_INSTRUCTION  instruction width
//   EXC_CAUSE_W       exception cause width
//   FQ_PTR_W          head/tail pointer width, log2(DEPTH)
//   FQ_CNT_W          occupancy counter width, one extra bit so full != empty
package fetch_pkg;

    localparam int FETCH_WIDTH      = 4;
    localparam int DEPTH            = 4;
    localparam int SIZE_PC          = 64;
    localparam int SIZE_INSTRUCTION = 32;
    localparam int EXC_CAUSE_W      = 8;
    localparam int FQ_PTR_W         = $clog2(DEPTH);
    localparam int FQ_CNT_W         = FQ_PTR_W + 1;

    typedef struct packed {
        logic [SIZE_PC-1:0]                            pc;
        logic [FETCH_WIDTH-1:0][SIZE_INSTRUCTION-1:0]  inst;
        logic [FETCH_WIDTH-1:0]                        instValid;
        logic                                          excValid;
        logic [EXC_CAUSE_W-1:0]                        excCause;
    } fetch_bundle_t;

    // A bundle carrying neither a valid slot nor an exception is a bubble;
    // it completes the handshake but is never stored.
    function automatic logic bundleHasContent(input fetch_bundle_t b);
        return (|b.instValid) | b.excValid;
    endfunction

endpackage

// File: rtl/fetchq_storage.sv
// fetchq_storage: DEPTH x fetch_bundle_t register array for the fetch bundle
// queue. One synchronous write port, one asynchronous read port. Data is not
// reset; validity is tracked entirely by the queue's pointers and count.
// Ports:
//   clk     clock
//   wrEn    write enable
//   wrAddr  write index
//   wrData  bundle to store
//   rdAddr  read index
//   rdData  bundle at rdAddr (combinational)
module fetchq_storage
    import fetch_pkg::*;
(
    input  logic                clk,
    input  logic                wrEn,
    input  logic [FQ_PTR_W-1:0] wrAddr,
    input  fetch_bundle_t       wrData,
    input  logic [FQ_PTR_W-1:0] rdAddr,
    output fetch_bundle_t       rdData
);

    fetch_bundle_t mem [DEPTH];

    // Write port; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue: decoupling FIFO between the fetch stage and decode.
// Captures one fetch bundle per cycle and presents them in order to decode
// over a valid/ready handshake. flush_i discards everything.
// Optional macro FETCHQ_BYPASS_EN: when the queue is empty, a non-empty
// incoming bundle is forwarded to the deq outputs in the same cycle.
// Ports:
//   clk, reset (async, active-low)
//   flush_i                        discard all entries
//   enqValid_i / enqReady_o        enqueue handshake
//   enqPC_i, enqInst_i, enqInstValid_i, enqExcValid_i, enqExcCause_i
//   deqValid_o / deqReady_i        dequeue handshake
//   deqPC_o, deqInst_o, deqInstValid_o, deqExcValid_o, deqExcCause_o
//   count_o                        occupancy
module fetch_bundle_queue
    import fetch_pkg::*;
(
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          flush_i,
    input  logic                                          enqValid_i,
    output logic                                          enqReady_o,
    input  logic [SIZE_PC-1:0]                            enqPC_i,
    input  logic [FETCH_WIDTH-1:0][SIZE_INSTRUCTION-1:0]  enqInst_i,
    input  logic [FETCH_WIDTH-1:0]                        enqInstValid_i,
    input  logic                                          enqExcValid_i,
    input  logic [EXC_CAUSE_W-1:0]                        enqExcCause_i,
    output logic                                          deqValid_o,
    input  logic                                          deqReady_i,
    output logic [SIZE_PC-1:0]                            deqPC_o,
    output logic [FETCH_WIDTH-1:0][SIZE_INSTRUCTION-1:0]  deqInst_o,
    output logic [FETCH_WIDTH-1:0]                        deqInstValid_o,
    output logic                                          deqExcValid_o,
    output logic [EXC_CAUSE_W-1:0]                        deqExcCause_o,
    output logic [FQ_CNT_W-1:0]                           count_o
);

    logic [FQ_PTR_W-1:0] head;
    logic [FQ_PTR_W-1:0] tail;
    logic [FQ_CNT_W-1:0] count;
    logic [FQ_CNT_W-1:0] countNext;

    fetch_bundle_t enqBundle;
    fetch_bundle_t headBundle;
    fetch_bundle_t deqBundle;

    logic enqHasContent;
    logic queueValid;
    logic bypassActive;
    logic bypassFire;
    logic enqFire;
    logic deqFire;
    logic wrEn;
    logic headAdvance;

    assign enqBundle.pc        = enqPC_i;
    assign enqBundle.inst      = enqInst_i;
    assign enqBundle.instValid = enqInstValid_i;
    assign enqBundle.excValid  = enqExcValid_i;
    assign enqBundle.excCause  = enqExcCause_i;

    assign enqHasContent = bundleHasContent(enqBundle);

    // Full refuses enqueue even if a dequeue frees a slot this same cycle.
    assign enqReady_o = (count != FQ_CNT_W'(DEPTH)) & ~flush_i;
    assign queueValid = (count != '0) & ~flush_i;

`ifdef FETCHQ_BYPASS_EN
    assign bypassActive = (count == '0) & ~flush_i & enqValid_i & enqHasContent;
`else
    assign bypassActive = 1'b0;
`endif

    assign deqValid_o  = queueValid | bypassActive;
    assign enqFire     = enqValid_i & enqReady_o;
    assign deqFire     = deqValid_o & deqReady_i;
    // A bundle consumed straight through the bypass never touches storage.
    assign bypassFire  = bypassActive & deqReady_i;
    assign wrEn        = enqFire & enqHasContent & ~bypassFire;
    assign headAdvance = deqFire & ~bypassFire;

    fetchq_storage uStorage (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (tail),
        .wrData (enqBundle),
        .rdAddr (head),
        .rdData (headBundle)
    );

    // Occupancy changes only when exactly one side moves.
    always_comb begin
        countNext = count;
        if (wrEn && !headAdvance) begin
            countNext = count + FQ_CNT_W'(1);
        end else if (!wrEn && headAdvance) begin
            countNext = count - FQ_CNT_W'(1);
        end
    end

    // Pointer and count state; flush wins over any handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wrEn) begin
                tail <= tail + FQ_PTR_W'(1);
            end
            if (headAdvance) begin
                head <= head + FQ_PTR_W'(1);
            end
            count <= countNext;
        end
    end

    // Deq data is forced to zero whenever nothing valid is presented.
    always_comb begin
        deqBundle = '0;
        if (bypassActive) begin
            deqBundle = enqBundle;
        end else if (queueValid) begin
            deqBundle = headBundle;
        end
    end

    assign deqPC_o        = deqBundle.pc;
    assign deqInst_o      = deqBundle.inst;
    assign deqInstValid_o = deqBundle.instValid;
    assign deqExcValid_o  = deqBundle.excValid;
    assign deqExcCause_o  = deqBundle.excCause;
    assign count_o        = count;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// tb_fetch_bundle_queue: self-checking bench for fetch_bundle_queue. A
// behavioural queue model predicts every output each cycle for directed
// scenarios followed by randomized traffic.
module tb_fetch_bundle_queue;
    import fetch_pkg::*;

    logic                                          clk;
    logic                                          reset;
    logic                                          flush_i;
    logic                                          enqValid_i;
    logic                                          enqReady_o;
    logic [SIZE_PC-1:0]                            enqPC_i;
    logic [FETCH_WIDTH-1:0][SIZE_INSTRUCTION-1:0]  enqInst_i;
    logic [FETCH_WIDTH-1:0]                        enqInstValid_i;
    logic                                          enqExcValid_i;
    logic [EXC_CAUSE_W-1:0]                        enqExcCause_i;
    logic                                          deqValid_o;
    logic                                          deqReady_i;
    logic [SIZE_PC-1:0]                            deqPC_o;
    logic [FETCH_WIDTH-1:0][SIZE_INSTRUCTION-1:0]  deqInst_o;
    logic [FETCH_WIDTH-1:0]                        deqInstValid_o;
    logic                                          deqExcValid_o;
    logic [EXC_CAUSE_W-1:0]                        deqExcCause_o;
    logic [FQ_CNT_W-1:0]                           count_o;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: an ordered list of the bundles decode has yet to see.
    fetch_bundle_t modelQ [$];

    fetch_bundle_queue dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .enqValid_i     (enqValid_i),
        .enqReady_o     (enqReady_o),
        .enqPC_i        (enqPC_i),
        .enqInst_i      (enqInst_i),
        .enqInstValid_i (enqInstValid_i),
        .enqExcValid_i  (enqExcValid_i),
        .enqExcCause_i  (enqExcCause_i),
        .deqValid_o     (deqValid_o),
        .deqReady_i     (deqReady_i),
        .deqPC_o        (deqPC_o),
        .deqInst_o      (deqInst_o),
        .deqInstValid_o (deqInstValid_o),
        .deqExcValid_o  (deqExcValid_o),
        .deqExcCause_o  (deqExcCause_o),
        .count_o        (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic fetch_bundle_t makeBundle(input logic [SIZE_PC-1:0] pc,
                                                 input logic [FETCH_WIDTH-1:0] mask,
                                                 input logic excV,
                                                 input logic [EXC_CAUSE_W-1:0] cause);
        fetch_bundle_t b;
        b.pc        = pc;
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            b.inst[s] = SIZE_INSTRUCTION'($urandom);
        end
        b.instValid = mask;
        b.excValid  = excV;
        b.excCause  = cause;
        return b;
    endfunction

    // Drives one cycle of inputs, checks every output against the model,
    // then advances the model across the clock edge.
    task automatic applyStimulus(input fetch_bundle_t b, input logic enqV,
                                 input logic deqR, input logic flush);
        fetch_bundle_t expHead;
        logic          expEnqReady;
        logic          expDeqValid;
        logic          hasContent;
        logic          bypass;
        int            occ;

        @(negedge clk);
        flush_i        = flush;
        enqValid_i     = enqV;
        deqReady_i     = deqR;
        enqPC_i        = b.pc;
        enqInst_i      = b.inst;
        enqInstValid_i = b.instValid;
        enqExcValid_i  = b.excValid;
        enqExcCause_i  = b.excCause;
        #1;

        occ         = modelQ.size();
        hasContent  = (b.instValid != '0) || b.excValid;
`ifdef FETCHQ_BYPASS_EN
        bypass      = (occ == 0) && !flush && enqV && hasContent;
`else
        bypass      = 1'b0;
`endif
        expEnqReady = (occ < DEPTH) && !flush;
        expDeqValid = ((occ > 0) && !flush) || bypass;
        expHead     = '0;
        if (bypass)            expHead = b;
        else if (expDeqValid)  expHead = modelQ[0];

        checkOutput("enqReady", 128'(enqReady_o), 128'(expEnqReady));
        checkOutput("deqValid", 128'(deqValid_o), 128'(expDeqValid));
        checkOutput("count", 128'(count_o), 128'(occ));
        checkOutput("deqPC", 128'(deqPC_o), 128'(expHead.pc));
        checkOutput("deqInst", 128'(deqInst_o), 128'(expHead.inst));
        checkOutput("deqInstValid", 128'(deqInstValid_o), 128'(expHead.instValid));
        checkOutput("deqExcValid", 128'(deqExcValid_o), 128'(expHead.excValid));
        checkOutput("deqExcCause", 128'(deqExcCause_o), 128'(expHead.excCause));

        @(posedge clk);
        if (flush) begin
            modelQ.delete();
        end else if (bypass && deqR) begin
            // consumed in flight, queue untouched
        end else begin
            if (expDeqValid && deqR) void'(modelQ.pop_front());
            if (enqV && expEnqReady && hasContent) modelQ.push_back(b);
        end
    endtask

    task automatic idleCycle(input logic deqR);
        applyStimulus(makeBundle('0, '0, 1'b0, '0), 1'b0, deqR, 1'b0);
    endtask

    initial begin
        reset          = 1'b0;
        flush_i        = 1'b0;
        enqValid_i     = 1'b0;
        deqReady_i     = 1'b0;
        enqPC_i        = '0;
        enqInst_i      = '0;
        enqInstValid_i = '0;
        enqExcValid_i  = 1'b0;
        enqExcCause_i  = '0;

        #12;
        checkOutput("resetCount", 128'(count_o), 128'(0));
        checkOutput("resetDeqValid", 128'(deqValid_o), 128'(0));
        checkOutput("resetEnqReady", 128'(enqReady_o), 128'(1));
        checkOutput("resetDeqPC", 128'(deqPC_o), 128'(0));
        @(negedge clk);
        reset = 1'b1;

        // Single bundle, decode always ready.
        applyStimulus(makeBundle(64'h1000, 4'hF, 1'b0, '0), 1'b1, 1'b1, 1'b0);
        idleCycle(1'b1);
        idleCycle(1'b1);

        // Fill to full, offer a fifth, then drain in order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(makeBundle(64'(i * 16), 4'hF, 1'b0, '0), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(makeBundle(64'h40, 4'hF, 1'b0, '0), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idleCycle(1'b1);

        // Steady streaming at occupancy 2, wrapping the pointers.
        applyStimulus(makeBundle(64'h100, 4'h3, 1'b0, '0), 1'b1, 1'b0, 1'b0);
        applyStimulus(makeBundle(64'h110, 4'h1, 1'b0, '0), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(makeBundle(64'h120 + 64'(i * 16), 4'hF, 1'b0, '0), 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) idleCycle(1'b1);

        // Bubble bundle and exception-only bundle.
        applyStimulus(makeBundle(64'h200, 4'h0, 1'b0, '0), 1'b1, 1'b0, 1'b0);
        applyStimulus(makeBundle(64'h210, 4'h0, 1'b1, 8'h01), 1'b1, 1'b0, 1'b0);
        idleCycle(1'b1);
        idleCycle(1'b1);

        // Flush at occupancy 3 with both handshakes offered.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(makeBundle(64'h300 + 64'(i * 16), 4'hF, 1'b0, '0), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(makeBundle(64'h340, 4'hF, 1'b0, '0), 1'b1, 1'b1, 1'b1);
        idleCycle(1'b1);

        // Asynchronous reset in the middle of a cycle at occupancy 2.
        applyStimulus(makeBundle(64'h400, 4'hF, 1'b0, '0), 1'b1, 1'b0, 1'b0);
        applyStimulus(makeBundle(64'h410, 4'hF, 1'b0, '0), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        enqValid_i = 1'b0;
        deqReady_i = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncRstCount", 128'(count_o), 128'(0));
        checkOutput("asyncRstDeqValid", 128'(deqValid_o), 128'(0));
        checkOutput("asyncRstDeqPC", 128'(deqPC_o), 128'(0));
        modelQ.delete();
        @(negedge clk);
        reset = 1'b1;

        // Empty queue, enqueue with decode ready (bypass when enabled).
        applyStimulus(makeBundle(64'h500, 4'hF, 1'b0, '0), 1'b1, 1'b1, 1'b0);
        idleCycle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [FETCH_WIDTH-1:0] mask;
            mask = ($urandom_range(0, 3) == 0) ? '0 : FETCH_WIDTH'($urandom);
            applyStimulus(makeBundle({$urandom, $urandom}, mask,
                                     ($urandom_range(0, 5) == 0),
                                     EXC_CAUSE_W'($urandom)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
